// File: rtl/lcd_bus_responder.sv
// HD44780-compatible display-side bus responder: decodes RS/RW/E cycles, holds a 128-byte
// DDRAM, address counter and display flags, and models the busy flag.
module lcd_bus_responder #(
    parameter int unsigned BUSY_SHORT = 2000,
    parameter int unsigned BUSY_LONG  = 82000,
    parameter int unsigned CNT_W      = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RS,
    input  logic       RW,
    input  logic       E,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       D_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_data
);

    logic [1:0] e_sync, rs_sync, rw_sync;
    logic [7:0] d_s1, d_s2;
    logic       e_prev;
    logic       e_s, rs_s, rw_s, fall;

    logic [7:0] ddram [128];

    logic [6:0]       ac_q, ac_d, ac_step;
    logic             id_q, id_d;
    logic             shift_q, shift_d;
    logic             disp_q, disp_d, curs_q, curs_d, blink_q, blink_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_active_q, fill_active_d;
    logic [6:0]       fill_idx_q, fill_idx_d;
    logic [7:0]       d_out_q, d_out_d;

    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       accept, load_short, load_long;

    // Entry-mode shift bit is kept for completeness but drives nothing.
    logic unused_shift;
    assign unused_shift = shift_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_sync  <= '0;
            rs_sync <= '0;
            rw_sync <= '0;
            d_s1    <= '0;
            d_s2    <= '0;
            e_prev  <= 1'b0;
        end else begin
            e_sync  <= {e_sync[0], E};
            rs_sync <= {rs_sync[0], RS};
            rw_sync <= {rw_sync[0], RW};
            d_s1    <= D_in;
            d_s2    <= d_s1;
            e_prev  <= e_s;
        end
    end

    assign e_s  = e_sync[1];
    assign rs_s = rs_sync[1];
    assign rw_s = rw_sync[1];
    assign fall = e_prev & ~e_s;

    assign accept  = fall & ~rw_s & ~busy_q;
    assign ac_step = id_q ? ac_q + 7'd1 : ac_q - 7'd1;

    always_comb begin
        ac_d          = ac_q;
        id_d          = id_q;
        shift_d       = shift_q;
        disp_d        = disp_q;
        curs_d        = curs_q;
        blink_d       = blink_q;
        busy_d        = busy_q;
        cnt_d         = cnt_q;
        fill_active_d = fill_active_q;
        fill_idx_d    = fill_idx_q;
        wr_en         = 1'b0;
        wr_addr       = ac_q;
        wr_data       = d_s2;
        load_short    = 1'b0;
        load_long     = 1'b0;

        // Busy only drops once both the countdown and any clear fill are done.
        if (busy_q) begin
            if (cnt_q == '0) begin
                if (!fill_active_q) begin
                    busy_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (fill_active_q) begin
            wr_en      = 1'b1;
            wr_addr    = fill_idx_q;
            wr_data    = 8'h20;
            fill_idx_d = fill_idx_q + 7'd1;
            if (fill_idx_q == 7'h7f) begin
                fill_active_d = 1'b0;
            end
        end

        if (fall && rw_s && rs_s) begin
            ac_d = ac_step;
        end

        if (accept) begin
            if (rs_s) begin
                wr_en      = 1'b1;
                wr_addr    = ac_q;
                wr_data    = d_s2;
                ac_d       = ac_step;
                load_short = 1'b1;
            end else if (d_s2[7]) begin
                ac_d       = d_s2[6:0];
                load_short = 1'b1;
            end else if (d_s2[6] || d_s2[5] || d_s2[4]) begin
                load_short = 1'b1;
            end else if (d_s2[3]) begin
                disp_d     = d_s2[2];
                curs_d     = d_s2[1];
                blink_d    = d_s2[0];
                load_short = 1'b1;
            end else if (d_s2[2]) begin
                id_d       = d_s2[1];
                shift_d    = d_s2[0];
                load_short = 1'b1;
            end else if (d_s2[1]) begin
                ac_d      = 7'd0;
                load_long = 1'b1;
            end else if (d_s2[0]) begin
                // Entry 0 is written now; the fill counter covers 1..127.
                ac_d          = 7'd0;
                id_d          = 1'b1;
                wr_en         = 1'b1;
                wr_addr       = 7'd0;
                wr_data       = 8'h20;
                fill_active_d = 1'b1;
                fill_idx_d    = 7'd1;
                load_long     = 1'b1;
            end
        end

        if (load_long) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(BUSY_LONG - 1);
        end else if (load_short) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(BUSY_SHORT - 1);
        end

        d_out_d = d_out_q;
        if (D_oe) begin
            d_out_d = rs_s ? ddram[ac_q] : {busy_q, ac_q};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ac_q          <= 7'd0;
            id_q          <= 1'b1;
            shift_q       <= 1'b0;
            disp_q        <= 1'b0;
            curs_q        <= 1'b0;
            blink_q       <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            fill_active_q <= 1'b0;
            fill_idx_q    <= 7'd0;
            d_out_q       <= 8'h00;
        end else begin
            ac_q          <= ac_d;
            id_q          <= id_d;
            shift_q       <= shift_d;
            disp_q        <= disp_d;
            curs_q        <= curs_d;
            blink_q       <= blink_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            fill_active_q <= fill_active_d;
            fill_idx_q    <= fill_idx_d;
            d_out_q       <= d_out_d;
        end
    end

    // DDRAM contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ddram[wr_addr] <= wr_data;
        end
    end

    assign D_oe       = e_s & rw_s;
    assign D_out      = d_out_q;
    assign busy       = busy_q;
    assign ac         = ac_q;
    assign display_on = disp_q;
    assign cursor_on  = curs_q;
    assign blink_on   = blink_q;
    assign dbg_data   = ddram[dbg_addr];

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with shortened busy times (4 / 16 cycles).
module tb_lcd_bus_responder;

    logic       clk;
    logic       rst;
    logic       RS, RW, E;
    logic [7:0] D_in;
    logic [7:0] D_out;
    logic       D_oe;
    logic       busy;
    logic [6:0] ac;
    logic       display_on, cursor_on, blink_on;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_data;

    int tests = 0;
    int fails = 0;

    lcd_bus_responder #(
        .BUSY_SHORT(4),
        .BUSY_LONG (16),
        .CNT_W     (17)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RS        (RS),
        .RW        (RW),
        .E         (E),
        .D_in      (D_in),
        .D_out     (D_out),
        .D_oe      (D_oe),
        .busy      (busy),
        .ac        (ac),
        .display_on(display_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns at the negedge right after the state-update edge.
    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        RS = rs; RW = 1'b0; D_in = d; E = 1'b1;
        repeat (3) @(negedge clk);
        E = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] data, output logic oe_before,
                            output logic oe_during, output logic oe_after);
        @(negedge clk);
        oe_before = D_oe;
        RS = rs; RW = 1'b1; E = 1'b1;
        repeat (4) @(negedge clk);
        oe_during = D_oe;
        data = D_out;
        E = 1'b0;
        repeat (3) @(negedge clk);
        oe_after = D_oe;
        RW = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; RS = 1'b0; RW = 1'b0; E = 1'b0; D_in = 8'h00; dbg_addr = 7'd0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, ac, display_on, cursor_on, blink_on} !== 11'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%b ac=%h flags=%b%b%b, required all 0",
                     busy, ac, display_on, cursor_on, blink_on);
        end
        tests++;
        if (D_oe !== 1'b0 || D_out !== 8'h00) begin
            fails++;
            $display("FAIL reset_bus: D_oe=%b D_out=%h, required 0/00", D_oe, D_out);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_status_read();
        logic [7:0] data;
        logic ob, od, oa;
        bus_read(1'b0, data, ob, od, oa);
        tests++;
        if (data !== 8'h00) begin
            fails++;
            $display("FAIL status_after_reset: D_out=%h, required 00", data);
        end
        tests++;
        if ({ob, od, oa} !== 3'b010) begin
            fails++;
            $display("FAIL oe_window: before/during/after=%b%b%b, required 010", ob, od, oa);
        end
    endtask

    task automatic test_display_ctrl();
        bus_write(1'b0, 8'h0F);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL busy_short_cycle%0d: busy=%b, required 1", i, busy);
            end
            @(negedge clk);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_short_end: busy=%b, required 0", busy);
        end
        tests++;
        if ({display_on, cursor_on, blink_on} !== 3'b111) begin
            fails++;
            $display("FAIL display_flags: DCB=%b%b%b, required 111",
                     display_on, cursor_on, blink_on);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] data;
        logic ob, od, oa;
        logic [7:0] exp_v [3];
        logic [6:0] addr_v [3];
        exp_v = '{8'h41, 8'h42, 8'h43};
        addr_v = '{7'h7E, 7'h7F, 7'h00};
        bus_write(1'b0, 8'hFE); wait_idle();
        tests++;
        if (ac !== 7'h7E) begin
            fails++;
            $display("FAIL set_ddram_addr: ac=%h, required 7e", ac);
        end
        for (int i = 0; i < 3; i++) begin
            bus_write(1'b1, exp_v[i]);
            wait_idle();
        end
        for (int i = 0; i < 3; i++) begin
            dbg_addr = addr_v[i];
            #1;
            tests++;
            if (dbg_data !== exp_v[i]) begin
                fails++;
                $display("FAIL wrap_data[%h]: got %h, required %h", addr_v[i], dbg_data, exp_v[i]);
            end
        end
        tests++;
        if (ac !== 7'h01) begin
            fails++;
            $display("FAIL wrap_ac: ac=%h, required 01", ac);
        end
        bus_read(1'b0, data, ob, od, oa);
        tests++;
        if (data !== 8'h01) begin
            fails++;
            $display("FAIL status_ac: D_out=%h, required 01", data);
        end
    endtask

    task automatic test_data_read();
        logic [7:0] data;
        logic ob, od, oa;
        bus_write(1'b0, 8'hFE); wait_idle();
        bus_read(1'b1, data, ob, od, oa);
        tests++;
        if (data !== 8'h41 || od !== 1'b1) begin
            fails++;
            $display("FAIL data_read: D_out=%h D_oe=%b, required 41/1", data, od);
        end
        tests++;
        if (ac !== 7'h7F || busy !== 1'b0) begin
            fails++;
            $display("FAIL data_read_ac: ac=%h busy=%b, required 7f/0", ac, busy);
        end
    endtask

    task automatic test_entry_dec();
        bus_write(1'b0, 8'h04); wait_idle();
        bus_write(1'b0, 8'h80); wait_idle();
        bus_write(1'b1, 8'h55); wait_idle();
        dbg_addr = 7'h00;
        #1;
        tests++;
        if (dbg_data !== 8'h55 || ac !== 7'h7F) begin
            fails++;
            $display("FAIL entry_dec: ddram[00]=%h ac=%h, required 55/7f", dbg_data, ac);
        end
    endtask

    task automatic test_clear();
        int n = 0;
        int bad = 0;
        bus_write(1'b0, 8'h01);
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (n != 128) begin
            fails++;
            $display("FAIL clear_busy_len: busy held %0d cycles, required 128", n);
        end
        for (int i = 0; i < 128; i++) begin
            dbg_addr = 7'(i);
            #1;
            if (dbg_data !== 8'h20) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL clear_fill: %0d entries not 20, required 0", bad);
        end
        tests++;
        if (ac !== 7'h00) begin
            fails++;
            $display("FAIL clear_ac: ac=%h, required 00", ac);
        end
    endtask

    task automatic test_write_while_busy();
        bus_write(1'b0, 8'h01);
        bus_write(1'b1, 8'h99);
        wait_idle();
        dbg_addr = 7'h00;
        #1;
        tests++;
        if (dbg_data !== 8'h20 || ac !== 7'h00) begin
            fails++;
            $display("FAIL dropped_write: ddram[00]=%h ac=%h, required 20/00", dbg_data, ac);
        end
    endtask

    task automatic test_mid_clear_reset();
        logic [7:0] exp_v [4];
        exp_v = '{8'h20, 8'h20, 8'h63, 8'h64};
        bus_write(1'b0, 8'h0F); wait_idle();
        bus_write(1'b0, 8'hB0); wait_idle();
        bus_write(1'b1, 8'h61); wait_idle();
        bus_write(1'b1, 8'h62); wait_idle();
        bus_write(1'b1, 8'h63); wait_idle();
        bus_write(1'b1, 8'h64); wait_idle();
        bus_write(1'b0, 8'h01);
        repeat (49) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || ac !== 7'h00 || display_on !== 1'b0) begin
            fails++;
            $display("FAIL midclear_reset: busy=%b ac=%h disp=%b, required 0/00/0",
                     busy, ac, display_on);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 7'(48 + i);
            #1;
            tests++;
            if (dbg_data !== exp_v[i]) begin
                fails++;
                $display("FAIL midclear_ddram[%0d]: got %h, required %h", 48 + i, dbg_data,
                         exp_v[i]);
            end
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL midclear_busy_after: busy=%b, required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_status_read();
        test_display_ctrl();
        test_wrap();
        test_data_read();
        test_entry_dec();
        test_clear();
        test_write_while_busy();
        test_mid_clear_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
